// File: rtl/axi_rr_arbiter.sv
// Two-requester round-robin arbiter and transaction sequencer for a single
// AXI-lite style slave. One transaction is in flight at a time. Writes run
// AW -> W -> B and reads run AR -> R. Each slave wait state has an abort
// timeout. The result is returned to the granted requester as a one-cycle
// done/err pulse.
module axi_rr_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            done,
  output logic [1:0]            err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  grant_id,
  output logic                  busy,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  output logic [DATA_W-1:0]     s_wdata,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  input  logic [1:0]            s_bresp,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_W-1:0]     s_rdata
);

  // The counter only has to hold 0..TIMEOUT-1. Reaching the last value
  // while still waiting aborts the transaction.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic                win;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  logic                gid_q;
  logic                last_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                waiting;
  logic                hs;
  logic                tmo;

  // Only the top bit of BRESP distinguishes error responses.
  logic                unused_bresp;
  assign unused_bresp = s_bresp[0];

  // Winner selection: a lone requester wins outright.
  // On a tie, the requester that did not win last time wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~last_q;
    end else begin
      win = req[1];
    end
    win_we    = win ? we[1] : we[0];
    win_addr  = win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    win_wdata = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A timeout in any wait state overrides the normal
  // transition and goes straight to DONE.
  always_comb begin
    state_d = state_q;
    waiting = 1'b0;
    hs      = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = win_we ? S_AW : S_AR;
        end
      end
      S_AW: begin
        waiting = 1'b1;
        hs      = s_awready;
        if (hs) state_d = S_W;
      end
      S_W: begin
        waiting = 1'b1;
        hs      = s_wready;
        if (hs) state_d = S_B;
      end
      S_B: begin
        waiting = 1'b1;
        hs      = s_bvalid;
        if (hs) state_d = S_DONE;
      end
      S_AR: begin
        waiting = 1'b1;
        hs      = s_arready;
        if (hs) state_d = S_R;
      end
      S_R: begin
        waiting = 1'b1;
        hs      = s_rvalid;
        if (hs) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    tmo = waiting && !hs && (cnt_q == TMO_LAST);
    if (tmo) begin
      state_d = S_DONE;
    end
  end

  // Datapath: grant latching, wait counter, response capture, fairness history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (state_q == S_IDLE && |req) begin
        gid_q   <= win;
        we_q    <= win_we;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
      end

      // Any state change clears the counter, so every wait state starts from zero.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (waiting) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (tmo) begin
        err_q <= 1'b1;
      end else if (state_q == S_B && s_bvalid) begin
        err_q <= s_bresp[1];
      end else if (state_q == S_R && s_rvalid) begin
        err_q   <= 1'b0;
        rdata_q <= s_rdata;
      end

      if (state_q == S_DONE) begin
        last_q <= gid_q;
      end
    end
  end

  // Outputs are decoded from the state alone. This keeps at most one
  // slave handshake line high per cycle. Address and data outputs read
  // zero outside their phases.
  always_comb begin
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_rready  = 1'b0;
    done      = 2'b00;
    err       = 2'b00;
    case (state_q)
      S_AW: begin
        s_awvalid = 1'b1;
        s_awaddr  = addr_q;
      end
      S_W: begin
        s_wvalid = 1'b1;
        s_wdata  = wdata_q;
      end
      S_B: begin
        s_bready = 1'b1;
      end
      S_AR: begin
        s_arvalid = 1'b1;
        s_araddr  = addr_q;
      end
      S_R: begin
        s_rready = 1'b1;
      end
      S_DONE: begin
        done[gid_q] = 1'b1;
        err[gid_q]  = err_q;
      end
      default: begin
      end
    endcase
  end

  assign rdata    = rdata_q;
  assign grant_id = gid_q;
  assign busy     = (state_q != S_IDLE);

endmodule
